// File: rtl/enc_onehot2bin_buf.sv
// enc_onehot2bin_buf: one-hot to binary encoder with error flags, saturating error count and output FIFO
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in/in_ready upstream one-hot vector handshake (in_ready registered)
//   out_valid/out_idx/out_err_zero/out_err_multi/out_ready  FIFO head handshake
//   err_cnt, clr_err     saturating count of accepted bad vectors, synchronous clear
module enc_onehot2bin_buf #(
    parameter int W     = 15,
    parameter int IDXW  = 4,
    parameter int DEPTH = 2,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [W-1:0]    in,
    output logic            in_ready,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic            out_err_zero,
    output logic            out_err_multi,
    input  logic            out_ready,
    output logic [ERRW-1:0] err_cnt,
    input  logic            clr_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            ez;
        logic            em;
    } ent_t;

    ent_t          mem [DEPTH];
    ent_t          enc;
    ent_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          push, pop;

    // Descending scan so the lowest set bit wins; x & (x-1) is nonzero iff two or more bits are set.
    always_comb begin
        enc.idx = '0;
        for (int i = W - 1; i >= 0; i--)
            if (in[i]) enc.idx = IDXW'(i);
        enc.ez = (in == '0);
        enc.em = |(in & (in - W'(1)));
    end

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            err_cnt  <= '0;
        end else begin
            wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
            cnt      <= cnt_nxt;
            // Registered from the next occupancy, so a pop never combinationally frees a full FIFO.
            in_ready <= cnt_nxt < (AW+1)'(DEPTH);
            err_cnt  <= clr_err ? '0 :
                        (push && (enc.ez || enc.em) && !(&err_cnt)) ? err_cnt + ERRW'(1) : err_cnt;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= enc;

    assign out_valid     = (cnt != '0);
    assign head          = out_valid ? mem[rd_ptr] : '0;
    assign out_idx       = head.idx;
    assign out_err_zero  = head.ez;
    assign out_err_multi = head.em;
endmodule

// File: tb/tb_enc_onehot2bin_buf.sv
// tb_enc_onehot2bin_buf: self-checking bench for enc_onehot2bin_buf (ERRW=2 to reach saturation)
module tb_enc_onehot2bin_buf;
    localparam int W = 15, IDXW = 4, DEPTH = 2, ERRW = 2;
    localparam int EMAX = (1 << ERRW) - 1;

    logic            clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr_err = 0;
    logic [W-1:0]    din = '0;
    logic            in_ready, out_valid, out_err_zero, out_err_multi;
    logic [IDXW-1:0] out_idx;
    logic [ERRW-1:0] err_cnt;

    enc_onehot2bin_buf #(.W(W), .IDXW(IDXW), .DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .in_ready(in_ready),
        .out_valid(out_valid), .out_idx(out_idx), .out_err_zero(out_err_zero),
        .out_err_multi(out_err_multi), .out_ready(out_ready), .err_cnt(err_cnt),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; bit z; bit m;} ref_t;
    typedef struct {logic [W-1:0] d; int idx; bit z; bit m;} vec_t;

    ref_t q[$];
    int   merr = 0;
    bit   mrdy = 0;
    int   tests = 0, fails = 0;

    function automatic ref_t ref_enc(input int d);
        ref_t r;
        r.z   = (d == 0);
        r.m   = ($countones(d) > 1);
        r.idx = (d == 0) ? 0 : $clog2(d & -d);
        return r;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_all();
        ref_t h;
        h = '{0, 0, 0};
        if (q.size() != 0) h = q[0];
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_idx", out_idx, h.idx);
        chk("out_err_zero", out_err_zero, h.z);
        chk("out_err_multi", out_err_multi, h.m);
        chk("in_ready", in_ready, mrdy);
        chk("err_cnt", err_cnt, merr);
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic clr);
        bit push, pop;
        ref_t r;
        in_valid = v; din = d; out_ready = ordy; clr_err = clr;
        @(posedge clk);
        r    = ref_enc(int'(d));
        pop  = (q.size() != 0) && ordy;
        push = v && mrdy;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(r);
        if (clr) merr = 0;
        else if (push && (r.z || r.m) && merr < EMAX) merr++;
        mrdy = (q.size() < DEPTH);
        #1;
        check_all();
    endtask

    vec_t tbl[8];

    initial begin
        tbl = '{'{15'h0001, 0, 0, 0}, '{15'h0200, 9, 0, 0}, '{15'h4000, 14, 0, 0},
                '{15'h0000, 0, 1, 0}, '{15'h0024, 2, 0, 1}, '{15'h7FFF, 0, 0, 1},
                '{15'h6000, 13, 0, 1}, '{15'h0080, 7, 0, 0}};

        // reset held three cycles, then released
        repeat (3) begin
            @(posedge clk); #1;
            check_all();
        end
        rst = 0;
        cyc(0, '0, 0, 0);
        chk("in_ready_after_reset", in_ready, 1);

        // single transfer
        cyc(1, 15'h0200, 1, 0);
        chk("single_idx", out_idx, 9);
        cyc(0, '0, 1, 0);
        chk("single_popped", out_valid, 0);

        // backpressure fill
        cyc(1, 15'h0001, 0, 0);
        cyc(1, 15'h4000, 0, 0);
        chk("bp_full", in_ready, 0);
        cyc(1, 15'h0010, 0, 0);
        chk("bp_head0", out_idx, 0);
        cyc(1, 15'h0010, 1, 0);
        chk("bp_head14", out_idx, 14);
        chk("bp_ready_back", in_ready, 1);
        cyc(1, 15'h0010, 1, 0);
        chk("bp_head4", out_idx, 4);
        cyc(0, '0, 1, 0);

        // error encoding
        cyc(0, '0, 1, 1);
        cyc(1, 15'h0000, 0, 0);
        cyc(1, 15'h0024, 0, 0);
        chk("err_zero_flag", out_err_zero, 1);
        chk("err_cnt_two", err_cnt, 2);
        cyc(0, '0, 1, 0);
        chk("err_multi_idx", out_idx, 2);
        chk("err_multi_flag", out_err_multi, 1);
        cyc(0, '0, 1, 0);

        // saturation and clear priority
        cyc(0, '0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 15'h0000, 1, 0);
            chk("sat_seq", err_cnt, (i < 3) ? i + 1 : 3);
        end
        cyc(1, 15'h0000, 1, 1);
        chk("clr_at_sat", err_cnt, 0);
        cyc(1, 15'h0003, 1, 0);
        cyc(1, 15'h0000, 1, 1);
        chk("clr_beats_inc", err_cnt, 0);
        cyc(0, '0, 1, 0);

        // table-driven single transfers
        for (int i = 0; i < 8; i++) begin
            cyc(1, tbl[i].d, 1, 0);
            chk("tbl_idx", out_idx, tbl[i].idx);
            chk("tbl_z", out_err_zero, tbl[i].z);
            chk("tbl_m", out_err_multi, tbl[i].m);
            cyc(0, '0, 1, 0);
        end

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] d;
            int k;
            k = $urandom_range(0, 3);
            d = (k == 1) ? '0 : (k == 2) ? W'($urandom) : (W'(1) << $urandom_range(0, W - 1));
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        // asynchronous reset with a full FIFO
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(1, 15'h0002, 0, 0);
        cyc(1, 15'h0004, 0, 0);
        chk("pre_reset_full", out_valid, 1);
        #3 rst = 1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 0);
        q.delete();
        merr = 0;
        mrdy = 0;
        @(posedge clk); #1;
        check_all();
        rst = 0;
        cyc(0, '0, 0, 0);
        cyc(1, 15'h0100, 0, 0);
        chk("post_reset_idx", out_idx, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
